// File: rtl/elevator_scan_scheduler.sv
// SCAN (collective-control) scheduler for a 4-floor car; one FSM decision per step_tick.
// Optional idle homing to floor 1 (index 0) is compiled in with `define SCHED_IDLE_HOME_EN.
module elevator_scan_scheduler #(
  parameter int DOOR_TICKS = 2,
  parameter int HOME_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_tick,
  input  logic [3:0] req_car,
  input  logic [2:0] req_up,
  input  logic [2:0] req_dn,
  output logic [1:0] floor,
  output logic [1:0] dir,
  output logic       door_open,
  output logic [9:0] pending
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DN   = 2'd2;
  localparam logic [1:0] ST_DOOR = 2'd3;

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);

  if (DOOR_TICKS < 1 || HOME_TICKS < 1) begin : g_param_check
    $error("DOOR_TICKS and HOME_TICKS must be at least 1");
  end

  // Per-floor call vectors packed back into the external pending layout.
  function automatic logic [9:0] pack(input logic [3:0] c, input logic [2:0] u,
                                      input logic [2:0] d);
    return {d[2], u[2], d[1], u[1], d[0], u[0], c};
  endfunction

  function automatic logic above(input logic [3:0] v, input logic [1:0] f);
    return |(v & (4'b1110 << f));
  endfunction

  function automatic logic below(input logic [3:0] v, input logic [1:0] f);
    return |(v & ~(4'b1111 << f));
  endfunction

  function automatic logic [1:0] dist_above(input logic [3:0] v, input logic [1:0] f);
    logic [3:0] s;
    s = v >> f;
    if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else return 2'd3;
  endfunction

  function automatic logic [1:0] dist_below(input logic [3:0] v, input logic [1:0] f);
    logic [3:0] s;
    s = v << (2'd3 - f);
    if (s[2]) return 2'd1;
    else if (s[1]) return 2'd2;
    else return 2'd3;
  endfunction

  logic [1:0]    state, state_n, floor_n, dir_n;
  logic          door_n, sweep_up, sweep_n;
  logic [DW-1:0] door_cnt, door_cnt_n;
  logic [9:0]    clr, absorb, set;
  logic [3:0]    car, up4, dn4, any_at, fmask, m_up, m_dn;
  logic [1:0]    nf_up, nf_dn;
  logic          ab_f, bl_f, ab_nu, bl_nd, stop_up, stop_dn;

  assign car    = pending[3:0];
  assign up4    = {1'b0, pending[8], pending[6], pending[4]};
  assign dn4    = {pending[9], pending[7], pending[5], 1'b0};
  assign any_at = car | up4 | dn4;
  assign fmask  = 4'b0001 << floor;
  assign ab_f   = above(any_at, floor);
  assign bl_f   = below(any_at, floor);

  // Next floor is pinned at the shaft ends so a forced move stops in place.
  assign nf_up   = (floor == 2'd3) ? floor : floor + 2'd1;
  assign nf_dn   = (floor == 2'd0) ? floor : floor - 2'd1;
  assign m_up    = 4'b0001 << nf_up;
  assign m_dn    = 4'b0001 << nf_dn;
  assign ab_nu   = above(any_at, nf_up);
  assign bl_nd   = below(any_at, nf_dn);
  assign stop_up = car[nf_up] | up4[nf_up] | (nf_up == 2'd3) | (dn4[nf_up] & ~ab_nu);
  assign stop_dn = car[nf_dn] | dn4[nf_dn] | (nf_dn == 2'd0) | (up4[nf_dn] & ~bl_nd);

  assign set    = pack(req_car, req_up, req_dn);
  assign absorb = (state == ST_DOOR) ?
                  pack(fmask, sweep_up ? fmask[2:0] : 3'b000, sweep_up ? 3'b000 : fmask[3:1]) :
                  10'd0;

`ifdef SCHED_IDLE_HOME_EN
  localparam int HW = (HOME_TICKS > 1) ? $clog2(HOME_TICKS) : 1;
  localparam logic [HW-1:0] HOME_LAST = HW'(HOME_TICKS - 1);
  logic [HW-1:0] idle_cnt, idle_cnt_n;
`endif

  always_comb begin
    state_n    = state;
    floor_n    = floor;
    dir_n      = dir;
    door_n     = door_open;
    sweep_n    = sweep_up;
    door_cnt_n = door_cnt;
    clr        = 10'd0;
`ifdef SCHED_IDLE_HOME_EN
    idle_cnt_n = (state == ST_IDLE && pending == 10'd0) ? idle_cnt : '0;
`endif
    if (step_tick) begin
      case (state)
        ST_IDLE: begin
          if (any_at[floor]) begin
            state_n    = ST_DOOR;
            door_n     = 1'b1;
            door_cnt_n = '0;
            clr        = pack(fmask, fmask[2:0], fmask[3:1]);
            sweep_n    = ab_f;
            dir_n      = ab_f ? DIR_UP : DIR_DN;
          end else if (ab_f && (!bl_f || dist_above(any_at, floor) <= dist_below(any_at, floor))) begin
            state_n = ST_UP;
            sweep_n = 1'b1;
            dir_n   = DIR_UP;
          end else if (bl_f) begin
            state_n = ST_DN;
            sweep_n = 1'b0;
            dir_n   = DIR_DN;
          end
`ifdef SCHED_IDLE_HOME_EN
          else if (idle_cnt == HOME_LAST) begin
            if (floor != 2'd0) begin
              state_n    = ST_DN;
              sweep_n    = 1'b0;
              dir_n      = DIR_DN;
              idle_cnt_n = '0;
            end
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
`endif
        end
        ST_UP: begin
          floor_n = nf_up;
          if (stop_up) begin
            if (!any_at[nf_up]) begin
              state_n = ST_IDLE;
              dir_n   = DIR_IDLE;
            end else begin
              state_n    = ST_DOOR;
              door_n     = 1'b1;
              door_cnt_n = '0;
              clr        = pack(m_up, m_up[2:0], ab_nu ? 3'b000 : m_up[3:1]);
              sweep_n    = ab_nu;
              dir_n      = ab_nu ? DIR_UP : DIR_DN;
            end
          end
        end
        ST_DN: begin
          floor_n = nf_dn;
          if (stop_dn) begin
            if (!any_at[nf_dn]) begin
              state_n = ST_IDLE;
              dir_n   = DIR_IDLE;
            end else begin
              state_n    = ST_DOOR;
              door_n     = 1'b1;
              door_cnt_n = '0;
              clr        = pack(m_dn, bl_nd ? 3'b000 : m_dn[2:0], m_dn[3:1]);
              sweep_n    = ~bl_nd;
              dir_n      = bl_nd ? DIR_DN : DIR_UP;
            end
          end
        end
        default: begin
          if (door_cnt == DOOR_LAST) begin
            door_n = 1'b0;
            if (sweep_up ? ab_f : bl_f) begin
              state_n = sweep_up ? ST_UP : ST_DN;
              dir_n   = sweep_up ? DIR_UP : DIR_DN;
            end else if (sweep_up ? bl_f : ab_f) begin
              // Reversing here serves this floor's opposite hall call without a second door cycle.
              sweep_n = ~sweep_up;
              state_n = sweep_up ? ST_DN : ST_UP;
              dir_n   = sweep_up ? DIR_DN : DIR_UP;
              clr     = pack(4'b0000, sweep_up ? 3'b000 : fmask[2:0],
                             sweep_up ? fmask[3:1] : 3'b000);
            end else begin
              state_n = ST_IDLE;
              dir_n   = DIR_IDLE;
            end
          end else begin
            door_cnt_n = door_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      floor     <= 2'd0;
      dir       <= DIR_IDLE;
      door_open <= 1'b0;
      sweep_up  <= 1'b1;
      door_cnt  <= '0;
      pending   <= 10'd0;
    end else begin
      state     <= state_n;
      floor     <= floor_n;
      dir       <= dir_n;
      door_open <= door_n;
      sweep_up  <= sweep_n;
      door_cnt  <= door_cnt_n;
      pending   <= (pending | (set & ~absorb)) & ~clr;
    end
  end

`ifdef SCHED_IDLE_HOME_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_cnt_n;
  end
`endif

endmodule
